// File: rtl/vga_dpram_gen2.sv
// True dual-port byte-write RAM on one clock, with a zero-fill clear engine.
// Port A wins byte conflicts on same-address dual writes; overlapping masks raise collision.
module vga_dpram_gen2 #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 14,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_en,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_din,
  output logic [DATA_W-1:0]   a_dout,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_din,
  output logic [DATA_W-1:0]   b_dout,
  output logic                b_rvalid,
  input  logic                clr_req,
  output logic                init_busy,
  output logic                collision
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_READY = 1'b0, ST_CLEAR = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                a_acc_s, b_acc_s, a_wr_s, b_wr_s, same_s;
  logic [NB-1:0]       b_we_eff_s;
  logic [DATA_W-1:0]   a_old_s, b_old_s, a_rd_s, b_rd_s;
  logic                a_v1_q, a_v1_d, b_v1_q, b_v1_d;
  logic [DATA_W-1:0]   a_d1_q, a_d1_d, b_d1_q, b_d1_d;
  logic                coll_q, coll_d;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB-1:0]     we);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return r;
  endfunction

  // Clear engine next state: sweep every word once, then serve ports until clr_req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port decode, read-during-write selection and first pipeline stage inputs.
  always_comb begin
    a_acc_s = a_en && (state_q == ST_READY);
    b_acc_s = b_en && (state_q == ST_READY);
    a_wr_s  = a_acc_s && (a_we != '0);
    b_wr_s  = b_acc_s && (b_we != '0);
    same_s  = (a_addr == b_addr);
    a_old_s = mem[a_addr];
    b_old_s = mem[b_addr];
    if (a_wr_s && same_s) begin
      b_we_eff_s = b_we & ~a_we;
    end else begin
      b_we_eff_s = b_we;
    end
    if ((RDW_MODE == 0) && a_wr_s) begin
      a_rd_s = merge_bytes(a_old_s, a_din, a_we);
    end else begin
      a_rd_s = a_old_s;
    end
    if ((RDW_MODE == 0) && b_wr_s) begin
      b_rd_s = merge_bytes(b_old_s, b_din, b_we);
    end else begin
      b_rd_s = b_old_s;
    end
    if (a_acc_s) begin
      a_d1_d = a_rd_s;
    end else begin
      a_d1_d = a_d1_q;
    end
    if (b_acc_s) begin
      b_d1_d = b_rd_s;
    end else begin
      b_d1_d = b_d1_q;
    end
    a_v1_d = a_acc_s;
    b_v1_d = b_acc_s;
    coll_d = a_wr_s && b_wr_s && same_s && ((a_we & b_we) != '0);
  end

  // Storage array; contents survive rst_n and are only zeroed by the clear sweep.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_wr_s && a_we[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
        if (b_wr_s && b_we_eff_s[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
      end
    end
  end

  // First read stage and collision flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
      coll_q <= 1'b0;
    end else begin
      a_v1_q <= a_v1_d;
      b_v1_q <= b_v1_d;
      a_d1_q <= a_d1_d;
      b_d1_q <= b_d1_d;
      coll_q <= coll_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              a_v2_q, b_v2_q;
    logic [DATA_W-1:0] a_d2_q, a_d2_d, b_d2_q, b_d2_d;

    // Second stage only reloads data when the first stage holds a result.
    always_comb begin
      if (a_v1_q) begin
        a_d2_d = a_d1_q;
      end else begin
        a_d2_d = a_d2_q;
      end
      if (b_v1_q) begin
        b_d2_d = b_d1_q;
      end else begin
        b_d2_d = b_d2_q;
      end
    end

    // Second read stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        a_d2_q <= a_d2_d;
        b_d2_q <= b_d2_d;
      end
    end

    assign a_dout   = a_d2_q;
    assign b_dout   = b_d2_q;
    assign a_rvalid = a_v2_q;
    assign b_rvalid = b_v2_q;
  end else begin : g_noreg
    assign a_dout   = a_d1_q;
    assign b_dout   = b_d1_q;
    assign a_rvalid = a_v1_q;
    assign b_rvalid = b_v1_q;
  end

  assign init_busy = (state_q == ST_CLEAR);
  assign collision = coll_q;

endmodule

// File: tb/tb_vga_dpram_gen2.sv
// Two instances: dut0 (L=1, write-first) and dut1 (L=2, read-first) share one stimulus
// and are compared every cycle against a word-level memory model.
module tb_vga_dpram_gen2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n, a_en, b_en, clr_req;
  logic [7:0]  a_we, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [63:0] a_din, b_din;
  logic [63:0] a_dout [2];
  logic [63:0] b_dout [2];
  logic        a_rv [2];
  logic        b_rv [2];
  logic        busy [2];
  logic        coll [2];

  logic [63:0] mm [DEPTH];
  bit          m_busy;
  int          m_cnt;
  logic [64:0] hold_a, hold_b;
  logic [63:0] ex_ad [2];
  logic [63:0] ex_bd [2];
  logic        ex_av [2];
  logic        ex_bv [2];
  logic        ex_col, ex_busy;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  vga_dpram_gen2 #(.DATA_W(64), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[0]), .a_rvalid(a_rv[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[0]), .b_rvalid(b_rv[0]),
    .clr_req(clr_req), .init_busy(busy[0]), .collision(coll[0]));

  vga_dpram_gen2 #(.DATA_W(64), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[1]), .a_rvalid(a_rv[1]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[1]), .b_rvalid(b_rv[1]),
    .clr_req(clr_req), .init_busy(busy[1]), .collision(coll[1]));

  function automatic logic [63:0] mrg(input logic [63:0] o, input logic [63:0] n, input logic [7:0] we);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (we[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic idle();
    a_en = 1'b0; b_en = 1'b0; clr_req = 1'b0;
    a_we = 8'h00; b_we = 8'h00; a_addr = 4'h0; b_addr = 4'h0; a_din = 64'h0; b_din = 64'h0;
  endtask

  task automatic set_a(input logic [7:0] we, input logic [3:0] ad, input logic [63:0] d);
    a_en = 1'b1; a_we = we; a_addr = ad; a_din = d;
  endtask

  task automatic set_b(input logic [7:0] we, input logic [3:0] ad, input logic [63:0] d);
    b_en = 1'b1; b_we = we; b_addr = ad; b_din = d;
  endtask

  task automatic rand_access();
    a_en = ($urandom_range(0, 3) != 0); b_en = ($urandom_range(0, 3) != 0);
    a_we = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
    b_we = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
    a_addr = 4'($urandom); b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom);
    a_din = {$urandom, $urandom}; b_din = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    m_busy = 1'b1; m_cnt = 0; hold_a = 65'd0; hold_b = 65'd0;
    ex_col = 1'b0; ex_busy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ex_ad[k] = 64'h0; ex_bd[k] = 64'h0; ex_av[k] = 1'b0; ex_bv[k] = 1'b0;
    end
  endtask

  // One clock: apply the spec rules to the model at the edge, return at the next falling edge.
  task automatic tick();
    logic [63:0] oa, ob;
    logic [64:0] ea [2];
    logic [64:0] eb [2];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin ea[k] = 65'd0; eb[k] = 65'd0; end
    if (!m_busy) begin
      oa = mm[a_addr]; ob = mm[b_addr];
      if (a_en) begin ea[0] = {1'b1, mrg(oa, a_din, a_we)}; ea[1] = {1'b1, oa}; end
      if (b_en) begin eb[0] = {1'b1, mrg(ob, b_din, b_we)}; eb[1] = {1'b1, ob}; end
      ex_col = a_en && b_en && (a_addr == b_addr) && ((a_we & b_we) != 8'h00);
      if (b_en) mm[b_addr] = mrg(mm[b_addr], b_din, b_we);
      if (a_en) mm[a_addr] = mrg(mm[a_addr], a_din, a_we);
      if (clr_req) begin m_busy = 1'b1; m_cnt = 0; end
    end else begin
      mm[m_cnt] = 64'h0; ex_col = 1'b0;
      if (m_cnt == DEPTH - 1) m_busy = 1'b0;
      m_cnt = (m_cnt + 1) % DEPTH;
    end
    ex_busy = m_busy;
    ex_av[0] = ea[0][64]; if (ea[0][64]) ex_ad[0] = ea[0][63:0];
    ex_bv[0] = eb[0][64]; if (eb[0][64]) ex_bd[0] = eb[0][63:0];
    ex_av[1] = hold_a[64]; if (hold_a[64]) ex_ad[1] = hold_a[63:0];
    ex_bv[1] = hold_b[64]; if (hold_b[64]) ex_bd[1] = hold_b[63:0];
    hold_a = ea[1]; hold_b = eb[1];
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    for (int i = 0; i < DEPTH; i++) mm[i] = 64'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL reset dut%0d got %h want %h", k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
    end
  endtask

  task automatic test_clear();
    int n;
    n = 0;
    set_a(8'hFF, 4'h0, 64'hDEAD_BEEF_0123_4567);
    rst_n = 1'b1;
    while (busy[0] && n < 40) begin
      tick();
      idle();
      n++;
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL clear_busy dut%0d got %h want %h", k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
    end
    tests++;
    if (n !== 16) begin fails++; $display("FAIL clear_len got %0d want 16", n); end
    for (int i = 0; i <= DEPTH; i++) begin
      idle();
      if (i < DEPTH) begin set_a(8'h00, 4'(i), 64'h0); set_b(8'h00, 4'(DEPTH - 1 - i), 64'h0); end
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL clear_read dut%0d got %h want %h", k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
      tests++;
      if (i < DEPTH && (a_rv[0] !== 1'b1 || a_dout[0] !== 64'h0)) begin
        fails++; $display("FAIL clear_zero addr %0d got %b/%h want 1/0", i, a_rv[0], a_dout[0]);
      end
    end
  endtask

  task automatic test_byte_write();
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: set_a(8'hFF, 4'h5, 64'h1122_3344_5566_7788);
        1: set_a(8'h80, 4'h5, 64'hAA00_0000_0000_0000);
        2: set_b(8'h00, 4'h5, 64'h0);
        default: ;
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL byte_write dut%0d got %h want %h", k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
      if (s >= 2) begin
        tests++;
        if (b_rv[s-2] !== 1'b1 || b_dout[s-2] !== 64'hAA22_3344_5566_7788) begin
          fails++; $display("FAIL byte_merge dut%0d got %b/%h want 1/aa22334455667788", s - 2, b_rv[s-2], b_dout[s-2]);
        end
      end
    end
  endtask

  task automatic test_rdw();
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: set_a(8'hFF, 4'h3, 64'h0);
        1: set_a(8'hFF, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF);
        default: ;
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL rdw dut%0d got %h want %h", k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
      tests++;
      if (s == 1 && (a_rv[0] !== 1'b1 || a_dout[0] !== 64'hFFFF_FFFF_FFFF_FFFF)) begin
        fails++; $display("FAIL rdw_first got %b/%h want 1/ffffffffffffffff", a_rv[0], a_dout[0]);
      end
      if (s == 2 && (a_rv[1] !== 1'b1 || a_dout[1] !== 64'h0)) begin
        fails++; $display("FAIL rdw_old got %b/%h want 1/0", a_rv[1], a_dout[1]);
      end
    end
  endtask

  task automatic test_collision(input bit disjoint);
    int pulses [2];
    logic [63:0] want;
    logic [3:0]  ad;
    logic [63:0] da, db;
    pulses[0] = 0; pulses[1] = 0;
    ad = disjoint ? 4'hC : 4'h9;
    da = disjoint ? {$urandom, $urandom} : 64'h1111_1111_1111_1111;
    db = disjoint ? {$urandom, $urandom} : 64'h2222_2222_2222_2222;
    want = disjoint ? {db[63:48], 32'h0, da[15:0]} : 64'h0000_2222_1111_1111;
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin set_a(disjoint ? 8'h03 : 8'h0F, ad, da); set_b(disjoint ? 8'hC0 : 8'h3C, ad, db); end
        2: set_b(8'h00, ad, 64'h0);
        default: ;
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        pulses[k] += int'(coll[k]);
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL collision dut%0d got %h want %h", k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
      if (s >= 2 && s <= 3) begin
        tests++;
        if (b_rv[s-2] !== 1'b1 || b_dout[s-2] !== want) begin
          fails++; $display("FAIL coll_word dut%0d got %b/%h want 1/%h", s - 2, b_rv[s-2], b_dout[s-2], want);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (pulses[k] !== (disjoint ? 0 : 1)) begin
        fails++; $display("FAIL coll_pulses dut%0d got %0d want %0d", k, pulses[k], disjoint ? 0 : 1);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_access();
      clr_req = ($urandom_range(0, 199) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL random c=%0d dut%0d got %h want %h", c, k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
    end
    idle();
    while (m_busy) tick();
  endtask

  task automatic test_clr_req();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      idle(); set_a(8'hFF, 4'(i), {$urandom, $urandom}); tick();
    end
    idle(); clr_req = 1'b1; tick();
    n = 0;
    while (busy[0] && n < 40) begin
      rand_access();
      clr_req = $urandom_range(0, 1) != 0;
      tick();
      n++;
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
            {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
          fails++;
          $display("FAIL clr_busy dut%0d got %h want %h", k,
                   {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                   {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
        end
      end
    end
    tests++;
    if (n !== 16) begin fails++; $display("FAIL clr_len got %0d want 16", n); end
    for (int i = 0; i < DEPTH; i++) begin
      idle(); set_b(8'h00, 4'(i), 64'h0); tick();
      tests++;
      if (b_rv[0] !== 1'b1 || b_dout[0] !== 64'h0) begin
        fails++; $display("FAIL clr_zero addr %0d got %b/%h want 1/0", i, b_rv[0], b_dout[0]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_reset_mid();
    int n;
    idle(); set_a(8'h00, 4'h1, 64'h0); set_b(8'h00, 4'h2, 64'h0); tick();
    idle();
    rst_n = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]} !==
          {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]}) begin
        fails++;
        $display("FAIL reset_mid dut%0d got %h want %h", k,
                 {a_rv[k], b_rv[k], coll[k], busy[k], a_dout[k], b_dout[k]},
                 {ex_av[k], ex_bv[k], ex_col, ex_busy, ex_ad[k], ex_bd[k]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (a_rv[1] !== 1'b0 || b_rv[1] !== 1'b0) begin
        fails++; $display("FAIL abort_rvalid got %b%b want 00", a_rv[1], b_rv[1]);
      end
    end
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy[0] && n < 40) begin tick(); n++; end
    tests++;
    if (n !== 16 || busy[1] !== 1'b0) begin
      fails++; $display("FAIL restart_len got %0d/%b want 16/0", n, busy[1]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_byte_write();
    test_rdw();
    test_collision(1'b0);
    test_collision(1'b1);
    test_random();
    test_clr_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
